// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: run-state encodings shared with display/VGA decode of run_state
package cpu_run_ctrl_pkg;
    localparam logic [1:0] RUN_ST_RESET = 2'd0;
    localparam logic [1:0] RUN_ST_RUN   = 2'd1;
    localparam logic [1:0] RUN_ST_HALT  = 2'd2;
    localparam logic [1:0] RUN_ST_STEP  = 2'd3;
endpackage

// File: rtl/cpu_run_ctrl_edge_det.sv
// edge_det: rising-edge detector; history resets to 1 so a level held through reset gives no edge
// ports: clk, rst (sync, active-high), level (sampled input), rise (level & ~previous sample)
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);
    logic prev;
    always_ff @(posedge clk)
        prev <= rst ? 1'b1 : level;
    assign rise = level & ~prev;
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: core reset stretch, run/halt/single-step clock-enable and latched interrupt request
// ports: clk, rst, ext_rst, debug_en, debug_step, interrupter, int_ack in;
//        cpu_rst, cpu_en, int_req, run_state[1:0], step_count[15:0] out (all registered/state-decoded)
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int RST_HOLD    = 16,
    parameter int STEP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_rst,
    input  logic        debug_en,
    input  logic        debug_step,
    input  logic        interrupter,
    input  logic        int_ack,
    output logic        cpu_rst,
    output logic        cpu_en,
    output logic        int_req,
    output logic [1:0]  run_state,
    output logic [15:0] step_count
);
    logic [1:0]  state;
    logic [15:0] hold_cnt;
    logic [7:0]  step_cnt;
    logic        int_pending;
    logic        step_rise;
    logic        int_rise;

    edge_det u_step_edge (.clk(clk), .rst(rst), .level(debug_step),  .rise(step_rise));
    edge_det u_int_edge  (.clk(clk), .rst(rst), .level(interrupter), .rise(int_rise));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN_ST_RESET;
            hold_cnt   <= 16'(RST_HOLD);
            step_cnt   <= '0;
            step_count <= '0;
        end else if (ext_rst) begin
            state    <= RUN_ST_RESET;
            hold_cnt <= 16'(RST_HOLD);
        end else begin
            case (state)
                RUN_ST_RESET: begin
                    if (hold_cnt != 16'd0)
                        hold_cnt <= hold_cnt - 16'd1;
                    else
                        state <= debug_en ? RUN_ST_HALT : RUN_ST_RUN;
                end
                RUN_ST_RUN:
                    if (debug_en) state <= RUN_ST_HALT;
                RUN_ST_HALT: begin
                    if (step_rise) begin
                        state      <= RUN_ST_STEP;
                        step_cnt   <= 8'(STEP_CYCLES - 1);
                        step_count <= step_count + 16'd1;
                    end else if (!debug_en) begin
                        state <= RUN_ST_RUN;
                    end
                end
                default: begin
                    if (step_cnt == 8'd0)
                        state <= RUN_ST_HALT;
                    else
                        step_cnt <= step_cnt - 8'd1;
                end
            endcase
        end
    end

    // a new edge beats a coincident acknowledge
    always_ff @(posedge clk) begin
        if (rst)
            int_pending <= 1'b0;
        else if (int_rise)
            int_pending <= 1'b1;
        else if (state == RUN_ST_RESET || int_ack)
            int_pending <= 1'b0;
    end

    assign cpu_rst   = (state == RUN_ST_RESET);
    assign cpu_en    = (state == RUN_ST_RUN) || (state == RUN_ST_STEP);
    assign run_state = state;
    assign int_req   = int_pending & ~cpu_rst;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: table-driven and directed checks of cpu_run_ctrl with RST_HOLD=16, STEP_CYCLES=3
module tb_cpu_run_ctrl;
    logic        clk = 1'b0;
    logic        rst, ext_rst, debug_en, debug_step, interrupter, int_ack;
    logic        cpu_rst, cpu_en, int_req;
    logic [1:0]  run_state;
    logic [15:0] step_count;
    int          checks = 0;
    int          errors = 0;

    typedef struct packed {
        logic er, de, ds, it, ia;
        logic cr, ce, iq;
        logic [1:0]  st;
        logic [15:0] sc;
    } vec_t;

    vec_t vecs [23];

    cpu_run_ctrl #(.RST_HOLD(16), .STEP_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .ext_rst(ext_rst), .debug_en(debug_en),
        .debug_step(debug_step), .interrupter(interrupter), .int_ack(int_ack),
        .cpu_rst(cpu_rst), .cpu_en(cpu_en), .int_req(int_req),
        .run_state(run_state), .step_count(step_count)
    );

    always #50 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic cr, input logic ce, input logic iq,
                           input logic [1:0] st, input logic [15:0] sc);
        chk({tag, " cpu_rst"}, int'(cpu_rst), int'(cr));
        chk({tag, " cpu_en"}, int'(cpu_en), int'(ce));
        chk({tag, " int_req"}, int'(int_req), int'(iq));
        chk({tag, " run_state"}, int'(run_state), int'(st));
        chk({tag, " step_count"}, int'(step_count), int'(sc));
    endtask

    initial begin
        //           er de ds it ia  cr ce iq st sc
        vecs[0]  = '{0, 0, 0, 1, 0,  0, 1, 1, 1, 0};
        vecs[1]  = '{0, 0, 0, 1, 0,  0, 1, 1, 1, 0};
        vecs[2]  = '{0, 0, 0, 0, 1,  0, 1, 0, 1, 0};
        vecs[3]  = '{0, 0, 0, 0, 1,  0, 1, 0, 1, 0};
        vecs[4]  = '{0, 0, 0, 1, 0,  0, 1, 1, 1, 0};
        vecs[5]  = '{0, 0, 0, 0, 0,  0, 1, 1, 1, 0};
        vecs[6]  = '{0, 0, 0, 1, 1,  0, 1, 1, 1, 0};
        vecs[7]  = '{0, 0, 0, 0, 1,  0, 1, 0, 1, 0};
        vecs[8]  = '{0, 1, 0, 0, 0,  0, 0, 0, 2, 0};
        vecs[9]  = '{0, 1, 1, 0, 0,  0, 1, 0, 3, 1};
        vecs[10] = '{0, 1, 0, 0, 0,  0, 1, 0, 3, 1};
        vecs[11] = '{0, 1, 1, 0, 0,  0, 1, 0, 3, 1};
        vecs[12] = '{0, 1, 0, 0, 0,  0, 0, 0, 2, 1};
        vecs[13] = '{0, 1, 0, 0, 0,  0, 0, 0, 2, 1};
        vecs[14] = '{0, 0, 1, 0, 0,  0, 1, 0, 3, 2};
        vecs[15] = '{0, 0, 0, 0, 0,  0, 1, 0, 3, 2};
        vecs[16] = '{0, 0, 0, 0, 0,  0, 1, 0, 3, 2};
        vecs[17] = '{0, 0, 0, 0, 0,  0, 0, 0, 2, 2};
        vecs[18] = '{0, 0, 0, 0, 0,  0, 1, 0, 1, 2};
        vecs[19] = '{0, 0, 0, 1, 0,  0, 1, 1, 1, 2};
        vecs[20] = '{1, 0, 0, 1, 0,  1, 0, 0, 0, 2};
        vecs[21] = '{1, 0, 0, 0, 0,  1, 0, 0, 0, 2};
        vecs[22] = '{1, 0, 0, 0, 0,  1, 0, 0, 0, 2};

        rst = 1'b1; ext_rst = 1'b0; debug_en = 1'b0;
        debug_step = 1'b0; interrupter = 1'b0; int_ack = 1'b0;
        tick;
        tick;
        chk_all("reset", 1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick;
            chk($sformatf("powerup hold %0d cpu_rst", i), int'(cpu_rst), 1);
        end
        tick;
        chk_all("powerup release", 1'b0, 1'b1, 1'b0, 2'd1, 16'd0);

        for (int i = 0; i < 23; i++) begin
            {ext_rst, debug_en, debug_step, interrupter, int_ack} =
                {vecs[i].er, vecs[i].de, vecs[i].ds, vecs[i].it, vecs[i].ia};
            tick;
            chk_all($sformatf("vec %0d", i), vecs[i].cr, vecs[i].ce, vecs[i].iq, vecs[i].st, vecs[i].sc);
        end

        ext_rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick;
            chk($sformatf("ext hold %0d cpu_rst", i), int'(cpu_rst), 1);
            chk($sformatf("ext hold %0d cpu_en", i), int'(cpu_en), 0);
        end
        tick;
        chk_all("ext release", 1'b0, 1'b1, 1'b0, 2'd1, 16'd2);

        debug_en = 1'b1; debug_step = 1'b1; rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 17; i++) tick;
        chk_all("held step halt", 1'b0, 1'b0, 1'b0, 2'd2, 16'd0);
        tick;
        tick;
        chk_all("held step no step", 1'b0, 1'b0, 1'b0, 2'd2, 16'd0);
        debug_step = 1'b0;
        tick;
        chk_all("held step release", 1'b0, 1'b0, 1'b0, 2'd2, 16'd0);
        debug_step = 1'b1;
        tick;
        chk_all("held step repress", 1'b0, 1'b1, 1'b0, 2'd3, 16'd1);
        debug_step = 1'b0;
        tick;
        tick;
        tick;
        chk_all("held step done", 1'b0, 1'b0, 1'b0, 2'd2, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step/reset sequencer for the 5-stage MIPS core. It sits between the board-level button/switch logic and `arc_cpu_wrap`, and generates the core's reset, its clock-enable (free run vs. single-step debug) and a latched interrupt request with acknowledge handshake. It replaces ad-hoc reset-stretch and step logic in the top level with one verifiable FSM.

## Interface
Parameters:
- `RST_HOLD`, 16, cycles `cpu_rst` stays high after `ext_rst` is sampled low (1..65535)
- `STEP_CYCLES`, 1, cycles `cpu_en` is high per single step (1..255)

Ports:
- `clk` input 1: CPU clock (10 MHz domain); single clock for the block
- `rst` input 1: synchronous, active-high block reset
- `ext_rst` input 1: active-high reset request (inverted RSTN), synchronous to `clk`
- `debug_en` input 1: 1 = debug (halt/step) mode, 0 = free run
- `debug_step` input 1: debounced step button level
- `interrupter` input 1: debounced interrupt button level
- `int_ack` input 1: core acknowledges interrupt (1-cycle pulse)
- `cpu_rst` output 1: reset to core
- `cpu_en` output 1: core clock-enable / advance
- `int_req` output 1: pending interrupt to core
- `run_state` output 2: current FSM state (debug display)
- `step_count` output 16: single steps taken since reset

## Operation
- FSM states: RESET=0, RUN=1, HALT=2, STEP=3.
- `rst`=1: state←RESET, hold counter←`RST_HOLD`, `step_count`←0, `int_pending`←0, `step_cnt`←0, edge-detector history regs←1 (a button held through reset yields no edge).
- RESET: `ext_rst`=1 → reload counter; else counter≠0 → decrement; else (counter=0, `ext_rst`=0) → HALT if `debug_en` else RUN.
- RUN: `debug_en`=1 → HALT.
- HALT: rising edge of `debug_step` → STEP, `step_cnt`←`STEP_CYCLES`-1, `step_count`+1 (wraps 0xFFFF→0). Else `debug_en`=0 → RUN. Step edge takes priority over `debug_en`=0 in the same cycle.
- STEP: `step_cnt`=0 → HALT, else decrement. Always ends in HALT, even if `debug_en` dropped mid-step. Step edges during STEP are discarded, not queued.
- From any state, `ext_rst`=1 → RESET with counter reloaded (priority over all other transitions). `rst` dominates `ext_rst`.
- Outputs decoded from the state register only: `cpu_rst`=(state==RESET); `cpu_en`=(state==RUN or STEP); `run_state`=state.
- Interrupt: a rising edge of `interrupter` sets `int_pending`. `int_ack` clears it. If both occur in the same cycle, set wins. `int_ack` while not pending is ignored. `int_req`=`int_pending` & ~`cpu_rst`. `int_pending` is cleared in RESET.

## Timing
- Reset values: `cpu_rst`=1, `cpu_en`=0, `int_req`=0, `run_state`=0, `step_count`=0.
- No combinational input→output paths; every output changes only on a `clk` edge.
- Reset release: with `ext_rst` low from edge E0, `cpu_rst` falls at edge E0+`RST_HOLD` (`RST_HOLD`+1 low-sampled edges including E0), and `cpu_en` rises at that same edge if `debug_en`=0.
- Step: `debug_step` rises, sampled at edge E. State=STEP after E. `cpu_en` is high for exactly `STEP_CYCLES` cycles, then state=HALT.
- Interrupt: `interrupter` rises, sampled at edge E. `int_req` is high after E and falls at the edge sampling `int_ack`=1.
- Edge detection: edge = level & ~previous-sample. Minimum of 1 cycle from edge sample to state change.

## Structure
- State encodings (`RUN_ST_RESET`, `RUN_ST_RUN`, `RUN_ST_HALT`, `RUN_ST_STEP`) go in shared `define.vh` so the display and VGA debug logic can decode `run_state`.
- Sub-module `edge_det`: 1-bit rising-edge detector with sync reset to history=1. It is instantiated twice (step, interrupt).
- Counters sized from parameters: hold counter 16 bits, step counter 8 bits.

## Test plan
- Power-up: `rst`=1 for 2 cycles, then `ext_rst`=0, `debug_en`=0, `RST_HOLD`=16 → `cpu_rst` high for 17 edges after `rst` release, then `cpu_en`=1, `run_state`=1.
- Reset mid-run: in RUN, `ext_rst`=1 for 3 cycles → next edge `cpu_rst`=1 and `cpu_en`=0. Run resumes 17 edges after `ext_rst` is sampled low. `int_req` cleared.
- Single step: `debug_en`=1, HALT, `STEP_CYCLES`=3, one `debug_step` press → `cpu_en` high for exactly 3 cycles, `step_count`=1, back in HALT. A second edge during STEP → ignored, `step_count` still 1.
- Held button through reset: `debug_step`=1 during `rst` and afterwards → no step occurs. Release and press again → one step.
- Interrupt handshake: press `interrupter` → `int_req`=1 the next cycle. `int_ack` pulse → `int_req`=0. A new edge coincident with `int_ack` → `int_req` stays 1.
- Mode switch: HALT with `debug_en` 1→0 → RUN the next cycle. `debug_en`=0 together with a step edge in HALT → STEP, then HALT, then RUN.
